// File: rtl/activation_pipe.sv
// activation_pipe: multi-lane activation (bypass/ReLU/leaky/clip) with
// saturation and a 2-stage elastic pipe. Optional stats: ACTIVATION_SAT_STATS_EN.
module activation_pipe #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_MAX   = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data
`ifdef ACTIVATION_SAT_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [15:0]            sat_count
`endif
);

    localparam int EW = IN_W + 1;

    localparam logic signed [EW-1:0] SAT_HI = EW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_LO = EW'(-(1 << (OUT_W - 1)));
    localparam logic signed [EW-1:0] CLIP_V = EW'(CLIP_MAX);

    if (OUT_W > IN_W) begin : g_bad_width
        $error("activation_pipe: OUT_W must not exceed IN_W");
    end

    if (CLIP_MAX < 0 || CLIP_MAX > (1 << (OUT_W - 1)) - 1) begin : g_bad_clip
        $error("activation_pipe: CLIP_MAX out of range");
    end

    // Activation of one lane, kept at IN_W+1 bits so no value is lost
    // before the saturation stage.
    function automatic logic signed [EW-1:0] act_lane(
        input logic signed [IN_W-1:0] x,
        input logic [1:0]             m
    );
        logic signed [EW-1:0] xe;
        logic signed [EW-1:0] y;
        logic                 neg;
        xe  = {x[IN_W-1], x};
        neg = x[IN_W-1];
        y   = xe;
        unique case (m)
            2'b00: y = xe;
            2'b01: y = neg ? '0 : xe;
            2'b10: y = neg ? (xe >>> LEAK_SHIFT) : xe;
            2'b11: y = neg ? '0 : ((xe > CLIP_V) ? CLIP_V : xe);
        endcase
        return y;
    endfunction

    logic                           s1_valid;
    logic [LANES-1:0][EW-1:0]       s1_data;
    logic                           s2_valid;
    logic [LANES*OUT_W-1:0]         s2_data;

    logic [LANES-1:0][EW-1:0]       act_v;
    logic [LANES*OUT_W-1:0]         sat_v;
    logic                           s1_load;
    logic                           s2_load;

`ifdef ACTIVATION_SAT_STATS_EN
    logic [LANES-1:0]               sat_flag;
    logic [LANES-1:0]               s2_sat;
    logic [16:0]                    sat_sum;
`endif

    // Stage load enables: a stage loads when empty or when its content leaves.
    always_comb begin
        s2_load  = !s2_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = !reset && s1_load;
    end

    // Per-lane activation of the incoming beat, using the beat's own mode.
    always_comb begin
        act_v = '0;
        for (int i = 0; i < LANES; i++) begin
            act_v[i] = act_lane(in_data[i*IN_W +: IN_W], mode);
        end
    end

    // Per-lane clamp of the S1 result into the signed OUT_W range.
    always_comb begin
        logic signed [EW-1:0] v;
        sat_v = '0;
`ifdef ACTIVATION_SAT_STATS_EN
        sat_flag = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            v = $signed(s1_data[i]);
            if (v > SAT_HI) begin
                sat_v[i*OUT_W +: OUT_W] = SAT_HI[OUT_W-1:0];
`ifdef ACTIVATION_SAT_STATS_EN
                sat_flag[i] = 1'b1;
`endif
            end else if (v < SAT_LO) begin
                sat_v[i*OUT_W +: OUT_W] = SAT_LO[OUT_W-1:0];
`ifdef ACTIVATION_SAT_STATS_EN
                sat_flag[i] = 1'b1;
`endif
            end else begin
                sat_v[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
            end
        end
    end

    // Stage 1 register: activated lanes at full precision.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= act_v;
            end
        end
    end

    // Stage 2 register: saturated lanes; data only refreshes with a real beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_v;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;

`ifdef ACTIVATION_SAT_STATS_EN
    // Saturation flags travel with the beat in S2.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_sat <= '0;
        end else if (s2_load && s1_valid) begin
            s2_sat <= sat_flag;
        end
    end

    // Counter candidate: current count plus clamped lanes leaving this cycle.
    always_comb begin
        sat_sum = {1'b0, sat_count};
        if (s2_valid && out_ready) begin
            for (int i = 0; i < LANES; i++) begin
                sat_sum = sat_sum + 17'(s2_sat[i]);
            end
        end
    end

    // Sticky saturation counter; clear wins over increment.
    always_ff @(posedge clock) begin
        if (reset || stats_clr) begin
            sat_count <= '0;
        end else if (sat_sum[16]) begin
            sat_count <= 16'hFFFF;
        end else begin
            sat_count <= sat_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed stimulus, queue-based reference model,
// per-cycle compare of handshake, latency and data.
module tb_activation_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int LANES = 4;
    localparam int LS    = 3;
    localparam int CLIP  = 6;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [1:0]             mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
`ifdef ACTIVATION_SAT_STATS_EN
    logic                   stats_clr;
    logic [15:0]            sat_count;
`endif

    activation_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES),
        .LEAK_SHIFT(LS), .CLIP_MAX(CLIP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .mode(mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef ACTIVATION_SAT_STATS_EN
        ,
        .stats_clr(stats_clr),
        .sat_count(sat_count)
`endif
    );

    typedef struct {
        logic [31:0] data;
        int          stamp;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   post_rst = 0;
    bit   pat_en = 0;
    int   pidx = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    function automatic logic [63:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] pk8(input int a, input int b,
                                        input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference: activation by plain integer arithmetic, then clamp.
    function automatic logic [31:0] model(input logic [63:0] d,
                                          input logic [1:0] m);
        logic [31:0]        r;
        logic signed [15:0] xs;
        int x, y, dv;
        r  = '0;
        dv = 1 << LS;
        for (int i = 0; i < 4; i++) begin
            xs = d[i*16 +: 16];
            x  = xs;
            case (m)
                2'd0: y = x;
                2'd1: y = (x < 0) ? 0 : x;
                2'd2: y = (x < 0) ? -((-x + dv - 1) / dv) : x;
                default: y = (x < 0) ? 0 : ((x > CLIP) ? CLIP : x);
            endcase
            if (y > 127) y = 127;
            if (y < -128) y = -128;
            r[i*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    // Per-cycle compare against the queue model.
    always @(negedge clock) begin
        bit   exp_ir;
        bit   exp_ov;
        ent_t e;
        if (reset) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL in_ready_rst got=%b want=0", in_ready);
            end
            q.delete();
            post_rst = 1;
        end else begin
            exp_ir = !(q.size() >= 2 && !out_ready);
            total++;
            if (in_ready !== exp_ir) begin
                bad++;
                $display("FAIL in_ready cyc=%0d got=%b want=%b",
                         cyc, in_ready, exp_ir);
            end
            exp_ov = q.size() > 0 && cyc >= q[0].stamp + 1;
            total++;
            if (out_valid !== exp_ov) begin
                bad++;
                $display("FAIL out_valid cyc=%0d got=%b want=%b",
                         cyc, out_valid, exp_ov);
            end
            if (post_rst) begin
                total++;
                if (out_data !== '0) begin
                    bad++;
                    $display("FAIL out_data_rst got=%h want=0", out_data);
                end
                post_rst = 0;
            end
            if (exp_ov && out_valid) begin
                total++;
                if (out_data !== q[0].data) begin
                    bad++;
                    $display("FAIL out_data cyc=%0d got=%h want=%h",
                             cyc, out_data, q[0].data);
                end
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                e.data  = model(in_data, mode);
                e.stamp = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic chk_model(input logic [63:0] d, input logic [1:0] m,
                             input logic [31:0] lit, input string nm);
        logic [31:0] got;
        got = model(d, m);
        total++;
        if (got !== lit) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, lit);
        end
    endtask

    task automatic tick_ready();
        if (pat_en) begin
            out_ready = (pidx % 3 == 0);
            pidx++;
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [1:0] m);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
            tick_ready();
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=no_accept want=accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
            tick_ready();
        end
    endtask

`ifdef ACTIVATION_SAT_STATS_EN
    task automatic chk_stat(input logic [15:0] want, input string nm);
        total++;
        if (sat_count !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, sat_count, want);
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 2'b00;
        out_ready = 1'b1;
`ifdef ACTIVATION_SAT_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        idle(2);

        chk_model(pk(-5, 0, 7, 300), 2'b01, pk8(0, 0, 7, 127), "m_relu");
        send(pk(-5, 0, 7, 300), 2'b01);
        idle(3);

        chk_model(pk(-1, -8, -9, -2000), 2'b10,
                  pk8(-1, -1, -2, -128), "m_leaky");
        chk_model(pk(-3, 4, 6, 100), 2'b11, pk8(0, 4, 6, 6), "m_clip");
        chk_model(pk(-300, 200, 127, -128), 2'b00,
                  pk8(-128, 127, 127, -128), "m_bypass");
        send(pk(-1, -8, -9, -2000), 2'b10);
        send(pk(-3, 4, 6, 100), 2'b11);
        send(pk(-300, 200, 127, -128), 2'b00);
        idle(4);

        chk_model(pk(-50, -50, -50, -50), 2'b00,
                  pk8(-50, -50, -50, -50), "m_mode00");
        chk_model(pk(-50, -50, -50, -50), 2'b01, pk8(0, 0, 0, 0), "m_mode01");
        send(pk(-50, -50, -50, -50), 2'b00);
        send(pk(-50, -50, -50, -50), 2'b01);
        idle(4);

        pidx = 0;
        pat_en = 1;
        tick_ready();
        for (int b = 0; b < 10; b++) begin
            send(pk(b * 97 - 400, 250 - b * 60, b * 3 - 12, -b * 130),
                 2'(b % 4));
        end
        idle(12);
        pat_en = 0;
        out_ready = 1'b1;
        idle(4);

        out_ready = 1'b0;
        send(pk(11, 22, 33, 44), 2'b00);
        send(pk(-11, -22, -33, -44), 2'b00);
        idle(2);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        idle(6);
        send(pk(1, 2, 3, 4), 2'b00);
        idle(4);

`ifdef ACTIVATION_SAT_STATS_EN
        stats_clr = 1'b1;
        @(posedge clock);
        #1 stats_clr = 1'b0;
        chk_stat(16'h0000, "stat_clr0");
        send(pk(400, -400, 5, 5), 2'b00);
        idle(3);
        chk_stat(16'h0002, "stat_two");
        for (int n = 0; n < 16383; n++) begin
            send(pk(400, -400, 400, -400), 2'b00);
        end
        idle(3);
        chk_stat(16'hFFFE, "stat_near");
        send(pk(400, -400, 400, -400), 2'b00);
        idle(3);
        chk_stat(16'hFFFF, "stat_stick");
        send(pk(400, -400, 400, -400), 2'b00);
        idle(3);
        chk_stat(16'hFFFF, "stat_stick2");
        send(pk(400, -400, 400, -400), 2'b00);
        @(posedge clock);
        #1 stats_clr = 1'b1;
        @(posedge clock);
        #1 stats_clr = 1'b0;
        chk_stat(16'h0000, "stat_clr_pri");
        idle(3);
        chk_stat(16'h0000, "stat_clr_hold");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
